image_stream_tx: RTL
====================

// Module: image_stream_tx
// PURPOSE
//  Frame-buffer pixel source feeding line_buffer_5x5 / the conv datapath.
//  Host loads a WIDTH x HEIGHT image into an internal RAM. On start, the block streams it
//  in raster order (row 0 col 0 first) as data_out/data_valid, with an optional idle gap
//  between pixels. Row-end and frame-end markers are emitted alongside the stream.
// PARAMETERS
//  DATA_BITS  8   pixel width
//  WIDTH      28  pixels per row
//  HEIGHT     28  rows per frame
//  ADDR_BITS  10  RAM address width; must satisfy 2**ADDR_BITS >= WIDTH*HEIGHT
// PORTS
//  clk         in   1          single clock, rising edge
//  rst_n       in   1          asynchronous active-low reset
//  wr_en       in   1          host RAM write strobe
//  wr_addr     in   ADDR_BITS  host write address (raster index row*WIDTH+col)
//  wr_data     in   DATA_BITS  host write pixel
//  start       in   1          begin streaming one frame (level-sampled in IDLE)
//  abort       in   1          synchronous stop; return to IDLE with no frame_done
//  gap_cfg     in   4          idle cycles inserted between issued pixels
//  data_out    out  DATA_BITS  pixel, valid when data_valid=1
//  data_valid  out  1          pixel strobe (drives line buffer data_valid)
//  data_eol    out  1          high with the last pixel of each row
//  data_eof    out  1          high with the final pixel of the frame
//  busy        out  1          state != IDLE
//  frame_done  out  1          one-cycle pulse after the final pixel
// BEHAVIOUR
//  - Reset: state IDLE; data_out=0, data_valid=0, data_eol=0, data_eof=0, busy=0,
//    frame_done=0, rd_addr/col/row/gap counters=0. RAM contents are not cleared.
//  - RAM: 1 write port, 1 read port; registered (1-cycle) read.
//  - Host writes: accepted only when busy=0. Writes with wr_addr >= WIDTH*HEIGHT are dropped.
//    Writes while busy=1 are dropped.
//  - FSM states IDLE, RUN, GAP, DRAIN:
//    IDLE: if start=1 -> latch gap_cfg, rd_addr=0, col=row=0 -> RUN. start in other states ignored.
//    RUN: issue read of rd_addr; advance col/row/rd_addr.
//         If rd_addr was WIDTH*HEIGHT-1 -> DRAIN.
//         Else if gap latched != 0 -> GAP (load counter = gap).
//         Else stay in RUN.
//    GAP: decrement counter; when it reaches 1 -> RUN. This gives exactly gap idle cycles
//         between issues.
//    DRAIN: the last pixel is presented this cycle -> IDLE; frame_done=1 on the next cycle.
//  - Latency: start high in IDLE at cycle T -> first read issued T+1 -> data_valid=1 at T+2.
//    data_valid/data_out/data_eol/data_eof are registered one cycle after each issue.
//  - Throughput: 1 pixel per (1+gap) cycles. With gap=0, the frame takes WIDTH*HEIGHT
//    consecutive valid cycles.
//  - data_eol=1 when the issued col==WIDTH-1. data_eof=1 when the issued index==WIDTH*HEIGHT-1
//    (data_eol is also 1 on that pixel). Both are 0 whenever data_valid=0.
//  - frame_done: exactly one cycle, the cycle after the data_eof pixel. busy=0 in that cycle,
//    and a new start is accepted in that cycle.
//  - abort=1 in any non-IDLE state -> IDLE next cycle. A read issued in the same cycle still
//    emits its pixel. No frame_done. abort has priority over start. abort in IDLE has no effect.
//  - Async reset mid-frame: all outputs return to reset values immediately.
//  - Counters: col wraps WIDTH-1 -> 0 and increments row. No arithmetic overflow is possible
//    within one frame.
// TESTING
//  1. Load ram[i]=i[7:0] for i=0..783; start, gap=0 -> 784 consecutive valid pixels 0,1,..,255,0,..;
//     first valid 2 cycles after start; data_eol at i=27,55,...; data_eof with i=783;
//     frame_done next cycle.
//  2. gap_cfg=3 -> exactly 3 non-valid cycles between each pair of valid pixels;
//     total frame 4*784-3 cycles from first to last valid.
//  3. Pulse start while busy, and write ram[0]=8'hAA while busy -> no restart; ram[0] is unchanged
//     on the next frame.
//  4. abort at pixel 100 -> at most one further valid pixel, then busy=0, no frame_done;
//     a new start replays from pixel 0.
//  5. rst_n low mid-frame -> data_valid/busy drop immediately; after release, start streams
//     the preloaded RAM correctly.
//  6. Hold start high continuously -> back-to-back frames: frame_done pulse, then the new first
//     pixel 2 cycles later; line_buffer_5x5 window_valid pattern is identical for both frames.

Source files
------------

// File: rtl/image_stream_tx.sv
// Frame-buffer pixel source: host loads a WIDTH x HEIGHT image into RAM, then the block
// streams it in raster order with optional idle gaps, row-end and frame-end markers.
module image_stream_tx #(
    parameter int DATA_BITS = 8,
    parameter int WIDTH     = 28,
    parameter int HEIGHT    = 28,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 start,
    input  logic                 abort,
    input  logic [3:0]           gap_cfg,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 data_eol,
    output logic                 data_eof,
    output logic                 busy,
    output logic                 frame_done,
    output logic [1:0]           dbg_state
);
    localparam int NPIX     = WIDTH * HEIGHT;
    localparam int COL_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_BITS = $clog2(HEIGHT + 1);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);
    localparam logic [COL_BITS-1:0]  COL_LAST  = COL_BITS'(WIDTH - 1);
    localparam logic [ROW_BITS-1:0]  ROW_LAST  = ROW_BITS'(HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [DATA_BITS-1:0] r_mem [0:NPIX-1];

    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_rd_addr;
    logic [COL_BITS-1:0]  r_col;
    logic [ROW_BITS-1:0]  r_row;
    logic [3:0]           r_gap;
    logic [3:0]           r_gap_cnt;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_valid;
    logic                 r_eol;
    logic                 r_eof;
    logic                 r_frame_done;

    logic w_issue;
    logic w_wr_ok;

    assign w_issue = (r_state == S_RUN);
    // Host writes are only safe while the stream is idle; out-of-image addresses are dropped.
    assign w_wr_ok = wr_en && (r_state == S_IDLE) && (wr_addr <= LAST_ADDR);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rd_addr    <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_gap        <= '0;
            r_gap_cnt    <= '0;
            r_data_out   <= '0;
            r_valid      <= 1'b0;
            r_eol        <= 1'b0;
            r_eof        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Markers are registered alongside the RAM read so they line up with data_out.
            r_valid      <= w_issue;
            r_eol        <= w_issue && (r_col == COL_LAST);
            r_eof        <= w_issue && (r_col == COL_LAST) && (r_row == ROW_LAST);
            r_frame_done <= (r_state == S_DRAIN) && !abort;
            if (w_issue) begin
                r_data_out <= r_mem[r_rd_addr];
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_gap     <= gap_cfg;
                        r_rd_addr <= '0;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_rd_addr == LAST_ADDR) begin
                        r_state <= S_DRAIN;
                    end else if (r_gap != 4'd0) begin
                        r_gap_cnt <= r_gap;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_gap_cnt == 4'd1) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_valid;
    assign data_eol   = r_eol;
    assign data_eof   = r_eof;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;
endmodule
